// File: rtl/idli_tb_uart_tx_m.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : idli_tb_uart_tx_m                                          |
// | Description : Bench-side UART transmitter feeding the core's RX line.    |
// |               Words queue in a small FIFO and are sent one frame at a    |
// |               time, only while the core reports it is stalled on RX.     |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module idli_tb_uart_tx_m #(
    parameter int DATA_W       = 16,
    parameter int CLKS_PER_BIT = 1,
    parameter int FIFO_DEPTH   = 4,
    parameter int GAP_CLKS     = 2
) (
    input  logic                          i_utx_gck,
    input  logic                          i_utx_rst,
    input  logic [DATA_W-1:0]             i_utx_data,
    input  logic                          i_utx_vld,
    output logic                          o_utx_rdy,
    input  logic                          i_utx_peer_rdy,
    output logic                          o_utx_tx,
    output logic                          o_utx_busy,
    output logic [$clog2(FIFO_DEPTH):0]   o_utx_level
);

    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int LVL_W   = PTR_W + 1;
    localparam int BIT_W   = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam int CPB_M1  = CLKS_PER_BIT - 1;
    localparam int GAP_M1  = (GAP_CLKS > 0) ? GAP_CLKS - 1 : 0;
    localparam int TMR_MAX = (CPB_M1 > GAP_M1) ? CPB_M1 : GAP_M1;
    localparam int TMR_W   = (TMR_MAX > 0) ? $clog2(TMR_MAX + 1) : 1;

    localparam logic [TMR_W-1:0] C_BIT_TMR  = TMR_W'(CPB_M1);
    localparam logic [TMR_W-1:0] C_GAP_TMR  = TMR_W'(GAP_M1);
    localparam logic [BIT_W-1:0] C_LAST_BIT = BIT_W'(DATA_W - 1);
    localparam logic [LVL_W-1:0] C_FULL     = LVL_W'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_STOP  = 3'd3,
        S_GAP   = 3'd4
    } state_t;

    logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q;
    logic [PTR_W-1:0]  rd_ptr_q;
    logic [LVL_W-1:0]  level_q;

    state_t            state_q, state_d;
    logic [TMR_W-1:0]  timer_q, timer_d;
    logic [BIT_W-1:0]  bit_q,   bit_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic              tx_q,    tx_d;

    logic              w_push;
    logic              w_pop;

    // Ready gates on reset so nothing is accepted while the block is held.
    assign o_utx_rdy   = !i_utx_rst && (level_q != C_FULL);
    assign w_push      = i_utx_vld && o_utx_rdy;
    // A pop only happens from IDLE, so a freshly pushed word waits a cycle.
    assign w_pop       = (state_q == S_IDLE) && (level_q != '0) && i_utx_peer_rdy;

    assign o_utx_tx    = tx_q;
    assign o_utx_busy  = (state_q != S_IDLE);
    assign o_utx_level = level_q;

    // FIFO storage: data is not reset, occupancy is tracked by the pointers/level.
    always_ff @(posedge i_utx_gck) begin
        if (w_push) begin
            mem_q[wr_ptr_q] <= i_utx_data;
        end
    end

    // FIFO pointers and level; reset empties the queue.
    always_ff @(posedge i_utx_gck) begin
        if (i_utx_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (w_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (w_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({w_push, w_pop})
                2'b10:   level_q <= level_q + 1'b1;
                2'b01:   level_q <= level_q - 1'b1;
                default: level_q <= level_q;
            endcase
        end
    end

    // Frame sequencer next state; tx_d is the line value for the next cycle.
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        tx_d    = tx_q;
        case (state_q)
            S_IDLE: begin
                tx_d = 1'b1;
                if (w_pop) begin
                    shift_d = mem_q[rd_ptr_q];
                    timer_d = C_BIT_TMR;
                    tx_d    = 1'b0;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (timer_q == '0) begin
                    timer_d = C_BIT_TMR;
                    bit_d   = '0;
                    tx_d    = shift_q[0];
                    state_d = S_DATA;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            S_DATA: begin
                if (timer_q == '0) begin
                    timer_d = C_BIT_TMR;
                    if (bit_q == C_LAST_BIT) begin
                        tx_d    = 1'b1;
                        state_d = S_STOP;
                    end else begin
                        bit_d   = bit_q + 1'b1;
                        shift_d = {1'b0, shift_q[DATA_W-1:1]};
                        tx_d    = shift_q[1];
                    end
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            S_STOP: begin
                tx_d = 1'b1;
                if (timer_q == '0) begin
                    if (GAP_CLKS == 0) begin
                        state_d = S_IDLE;
                    end else begin
                        timer_d = C_GAP_TMR;
                        state_d = S_GAP;
                    end
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            S_GAP: begin
                tx_d = 1'b1;
                if (timer_q == '0) begin
                    state_d = S_IDLE;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            default: begin
                tx_d    = 1'b1;
                state_d = S_IDLE;
            end
        endcase
    end

    // Sequencer registers; reset abandons any partial frame with the line high.
    always_ff @(posedge i_utx_gck) begin
        if (i_utx_rst) begin
            state_q <= S_IDLE;
            timer_q <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_idli_tb_uart_tx_m.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_idli_tb_uart_tx_m                                       |
// | Description : Self-checking bench for idli_tb_uart_tx_m. Two instances:  |
// |               A uses default timing, B uses CLKS_PER_BIT=3, GAP_CLKS=0.  |
// |               Expected line waveforms come from a word queue model.      |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_idli_tb_uart_tx_m;

    localparam int DW    = 16;
    localparam int DEPTH = 4;
    localparam int LW    = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          vld;
    logic          peer;
    logic [DW-1:0] data;
    logic          sel;   // 0 = instance A, 1 = instance B

    logic          a_vld, a_peer, a_rdy, a_tx, a_busy;
    logic          b_vld, b_peer, b_rdy, b_tx, b_busy;
    logic [LW-1:0] a_lvl, b_lvl;

    logic          tx, busy, rdy;
    logic [LW-1:0] lvl;
    int            cpb;
    int            gap;

    int            n_pass  = 0;
    int            n_fail  = 0;
    int            n_total = 0;

    logic [DW-1:0] model_q [$];   // words the FIFO should hold, in send order

    always #5 clk = ~clk;

    assign a_vld  = vld  && (sel == 1'b0);
    assign a_peer = peer && (sel == 1'b0);
    assign b_vld  = vld  && (sel == 1'b1);
    assign b_peer = peer && (sel == 1'b1);

    assign tx   = sel ? b_tx   : a_tx;
    assign busy = sel ? b_busy : a_busy;
    assign rdy  = sel ? b_rdy  : a_rdy;
    assign lvl  = sel ? b_lvl  : a_lvl;
    assign cpb  = sel ? 3 : 1;
    assign gap  = sel ? 0 : 2;

    idli_tb_uart_tx_m #(.DATA_W(DW), .CLKS_PER_BIT(1), .FIFO_DEPTH(DEPTH), .GAP_CLKS(2)) u_dut_a (
        .i_utx_gck      (clk),
        .i_utx_rst      (rst),
        .i_utx_data     (data),
        .i_utx_vld      (a_vld),
        .o_utx_rdy      (a_rdy),
        .i_utx_peer_rdy (a_peer),
        .o_utx_tx       (a_tx),
        .o_utx_busy     (a_busy),
        .o_utx_level    (a_lvl)
    );

    idli_tb_uart_tx_m #(.DATA_W(DW), .CLKS_PER_BIT(3), .FIFO_DEPTH(DEPTH), .GAP_CLKS(0)) u_dut_b (
        .i_utx_gck      (clk),
        .i_utx_rst      (rst),
        .i_utx_data     (data),
        .i_utx_vld      (b_vld),
        .o_utx_rdy      (b_rdy),
        .i_utx_peer_rdy (b_peer),
        .o_utx_tx       (b_tx),
        .o_utx_busy     (b_busy),
        .o_utx_level    (b_lvl)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h (inst %0d, t=%0t)", tag, obs, exp, sel, $time);
        end
    endtask

    // Called at a negedge; leaves the bench just after the next negedge.
    task automatic push(input logic [DW-1:0] w);
        data = w;
        vld  = 1'b1;
        @(negedge clk);
        vld  = 1'b0;
        if (model_q.size() < DEPTH) model_q.push_back(w);
    endtask

    task automatic do_reset();
        rst  = 1'b1;
        vld  = 1'b0;
        peer = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_tx",    tx,   1);
        chk("rst_busy",  busy, 0);
        chk("rst_level", lvl,  0);
        chk("rst_rdy",   rdy,  0);
        rst = 1'b0;
        model_q.delete();
        #1;
        chk("post_rst_rdy", rdy, 1);
        @(negedge clk);
    endtask

    // Waits (bounded) for a start bit; waited = negedges advanced.
    task automatic wait_start(output int waited);
        waited = 0;
        while (tx !== 1'b0 && waited < 400) begin
            @(negedge clk);
            waited++;
        end
        chk("start_seen", tx, 0);
    endtask

    // Checks one whole frame plus gap against the head of the model queue.
    // Ends on the negedge of the last stop/gap cycle.
    task automatic check_frame(input string tag, output int waited);
        logic [DW-1:0] w;
        logic          exp_bit;
        wait_start(waited);
        if (model_q.size() == 0) begin
            chk({tag, "_model_empty"}, 1, 0);
            return;
        end
        w = model_q.pop_front();
        for (int b = 0; b < DW + 2; b++) begin
            if (b == 0)           exp_bit = 1'b0;
            else if (b == DW + 1) exp_bit = 1'b1;
            else                  exp_bit = w[b-1];
            for (int c = 0; c < cpb; c++) begin
                if (b != 0 || c != 0) @(negedge clk);
                chk($sformatf("%s_line_b%0d", tag, b), tx, exp_bit);
                chk($sformatf("%s_busy_b%0d", tag, b), busy, 1);
            end
        end
        for (int g = 0; g < gap; g++) begin
            @(negedge clk);
            chk($sformatf("%s_gap_tx%0d", tag, g), tx, 1);
            chk($sformatf("%s_gap_busy%0d", tag, g), busy, 1);
        end
    endtask

    task automatic scen_single(input logic [DW-1:0] w);
        int waited;
        peer = 1'b1;
        push(w);
        check_frame("s2", waited);
        @(negedge clk);
        chk("s2_idle_busy", busy, 0);
        chk("s2_idle_tx",   tx,   1);
        peer = 1'b0;
    endtask

    task automatic scen_overflow(input logic [DW-1:0] w0, input logic [DW-1:0] w1,
                                 input logic [DW-1:0] w2, input logic [DW-1:0] w3,
                                 input logic [DW-1:0] w4);
        logic [DW-1:0] ws [5];
        int            waited;
        int            bad;
        ws = '{w0, w1, w2, w3, w4};
        peer = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (i == 4) chk("s4_rdy_full", rdy, 0);
            push(ws[i]);
        end
        chk("s4_level_full", lvl, 4);
        chk("s4_rdy_after",  rdy, 0);
        peer = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check_frame($sformatf("s4_f%0d", i), waited);
            if (i > 0) chk($sformatf("s4_sep%0d", i), gap + waited - 1, gap + 1);
        end
        bad = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0) bad++;
        end
        chk("s4_no_fifth", bad, 0);
        chk("s4_level_end", lvl, 0);
        peer = 1'b0;
    endtask

    initial begin
        logic [DW-1:0] w1, w2, w3;
        int            waited;
        int            bad;

        sel  = 1'b0;
        rst  = 1'b1;
        vld  = 1'b0;
        peer = 1'b0;
        data = '0;

        // Scenario 1: reset values.
        do_reset();

        // Scenario 2: known pattern, then a random word.
        scen_single(16'hA5C3);
        scen_single(DW'($urandom));

        // Scenario 3: word waits while the peer is not stalled.
        w1 = DW'($urandom);
        push(w1);
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0) bad++;
        end
        chk("s3_hold_quiet", bad, 0);
        chk("s3_hold_level", lvl, 1);
        peer = 1'b1;
        @(negedge clk);
        chk("s3_start_tx",  tx,  0);
        chk("s3_start_lvl", lvl, 0);
        check_frame("s3", waited);
        @(negedge clk);
        peer = 1'b0;

        // Scenario 4: overflow and ordered drain.
        scen_overflow(16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'h0005);

        // Scenario 5: push on the same edge as the IDLE pop.
        w1 = DW'($urandom);
        w2 = DW'($urandom);
        w3 = DW'($urandom);
        push(w1);
        push(w2);
        peer = 1'b1;
        check_frame("s5_a", waited);
        @(negedge clk);
        chk("s5_idle_busy", busy, 0);
        chk("s5_pre_level", lvl,  1);
        data = w3;
        vld  = 1'b1;
        if (model_q.size() < DEPTH) model_q.push_back(w3);
        @(negedge clk);
        vld  = 1'b0;
        chk("s5_level_same", lvl, 1);
        chk("s5_start",      tx,  0);
        check_frame("s5_b", waited);
        check_frame("s5_c", waited);
        @(negedge clk);
        peer = 1'b0;

        // Scenario 6: reset during data bit 7 flushes queue and frame.
        w1 = DW'($urandom);
        w2 = DW'($urandom);
        push(w1);
        push(w2);
        peer = 1'b1;
        wait_start(waited);
        repeat (8 * cpb) @(negedge clk);
        chk("s6_bit7", tx, w1[7]);
        rst = 1'b1;
        @(negedge clk);
        chk("s6_rst_tx",   tx,   1);
        chk("s6_rst_lvl",  lvl,  0);
        chk("s6_rst_busy", busy, 0);
        rst = 1'b0;
        model_q.delete();
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0) bad++;
        end
        chk("s6_quiet", bad, 0);
        w3 = DW'($urandom);
        push(w3);
        check_frame("s6_new", waited);
        @(negedge clk);
        peer = 1'b0;

        // Instance B: slower bits, no gap.
        sel = 1'b1;
        do_reset();
        scen_single(16'hA5C3);
        scen_single(DW'($urandom));
        scen_overflow(DW'($urandom), DW'($urandom), DW'($urandom), DW'($urandom), DW'($urandom));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish (passed %0d of %0d)", n_pass, n_total);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
